// File: rtl/counter_seq_ctrl_if.sv
// Control, configuration and status bundle between a sequencer master and counter_seq_ctrl.
interface counter_seq_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int NSW   = 4
);
  logic             start;
  logic             abort;
  logic             pause;
  logic [WIDTH-1:0] cfg_limit;
  logic             cfg_dir;
  logic             cfg_pingpong;
  logic [NSW-1:0]   cfg_sweeps;
  logic [WIDTH-1:0] count;
  logic             mode;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, pause, cfg_limit, cfg_dir, cfg_pingpong, cfg_sweeps,
    input  count, mode, busy, done
  );

  modport slave (
    input  start, abort, pause, cfg_limit, cfg_dir, cfg_pingpong, cfg_sweeps,
    output count, mode, busy, done
  );
endinterface

// File: rtl/counter_seq_ctrl.sv
// Up/down/ping-pong sweep counter sequencer with sweep-count completion.
// Optional freeze input enabled by defining COUNTER_SEQ_PAUSE_EN.
module counter_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int NSW   = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  counter_seq_ctrl_if.slave bus
);

  // state   | meaning
  // ST_IDLE | waiting for start, outputs hold
  // ST_UP   | counting up towards the latched limit
  // ST_DN   | counting down towards zero
  // ST_FIN  | one-cycle done pulse, then idle
  typedef enum logic [1:0] {ST_IDLE, ST_UP, ST_DN, ST_FIN} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             mode_q, mode_d;
  logic [NSW-1:0]   s_q, s_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic             pp_q, pp_d;
  logic [NSW-1:0]   n_q, n_d;

  logic             pause_act;
  logic             at_end;
  logic [NSW-1:0]   s_inc;

`ifdef COUNTER_SEQ_PAUSE_EN
  assign pause_act = bus.pause;
`else
  logic unused_pause;
  assign unused_pause = bus.pause;
  assign pause_act    = 1'b0;
`endif

  assign s_inc  = s_q + NSW'(1);
  assign at_end = ((state_q == ST_UP) && (out_q == lim_q)) ||
                  ((state_q == ST_DN) && (out_q == '0));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      mode_q  <= 1'b1;
      s_q     <= '0;
      lim_q   <= '0;
      pp_q    <= 1'b0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      mode_q  <= mode_d;
      s_q     <= s_d;
      lim_q   <= lim_d;
      pp_q    <= pp_d;
      n_q     <= n_d;
    end
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    mode_d  = mode_q;
    s_d     = s_q;
    lim_d   = lim_q;
    pp_d    = pp_q;
    n_d     = n_q;

    if (bus.abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            lim_d = bus.cfg_limit;
            pp_d  = bus.cfg_pingpong;
            n_d   = bus.cfg_sweeps;
            s_d   = '0;
            if (bus.cfg_dir) begin
              out_d   = '0;
              mode_d  = 1'b1;
              state_d = ST_UP;
            end else begin
              out_d   = bus.cfg_limit;
              mode_d  = 1'b0;
              state_d = ST_DN;
            end
          end
        end
        ST_UP, ST_DN: begin
          if (!pause_act) begin
            if (at_end) begin
              s_d = s_inc;
              if ((n_q != '0) && (s_inc == n_q)) begin
                state_d = ST_FIN;
              end else if (pp_q) begin
                // A zero limit pins the count at 0 even while direction flips.
                if (state_q == ST_UP) begin
                  state_d = ST_DN;
                  mode_d  = 1'b0;
                  out_d   = (lim_q == '0) ? '0 : lim_q - WIDTH'(1);
                end else begin
                  state_d = ST_UP;
                  mode_d  = 1'b1;
                  out_d   = (lim_q == '0) ? '0 : WIDTH'(1);
                end
              end else begin
                out_d = (state_q == ST_UP) ? '0 : lim_q;
              end
            end else begin
              out_d = (state_q == ST_UP) ? out_q + WIDTH'(1) : out_q - WIDTH'(1);
            end
          end
        end
        ST_FIN: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign bus.count = out_q;
  assign bus.mode  = mode_q;
  assign bus.busy  = (state_q == ST_UP) || (state_q == ST_DN);
  assign bus.done  = (state_q == ST_FIN);

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Bench for counter_seq_ctrl: a trace-based run model checked every cycle plus literal vectors.
module tb_counter_seq_ctrl;
  localparam int WIDTH = 4;
  localparam int NSW   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  counter_seq_ctrl_if #(.WIDTH(WIDTH), .NSW(NSW)) bus ();
  counter_seq_ctrl #(.WIDTH(WIDTH), .NSW(NSW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: a run is the list of (count, mode) values it shows, built from the config at start.
  int tr_o[$];
  int tr_m[$];
  int m_out = 0, m_mode = 1, m_busy = 0, m_done = 0, m_valid = 0;

  task automatic build_trace(input int lim, input int dir, input int pp, input int n);
    int sw;
    int up;
    int first;
    int last;
    tr_o.delete();
    tr_m.delete();
    sw = 0;
    up = dir;
    while (((n == 0) || (sw < n)) && (tr_o.size() < 200)) begin
      if ((sw == 0) || (pp == 0)) first = up ? 0 : lim;
      else if (lim == 0) first = 0;
      else first = up ? 1 : lim - 1;
      last = up ? lim : 0;
      if (up != 0) begin
        for (int v = first; v <= last; v++) begin tr_o.push_back(v); tr_m.push_back(1); end
      end else begin
        for (int v = first; v >= last; v--) begin tr_o.push_back(v); tr_m.push_back(0); end
      end
      sw++;
      if (pp != 0) up = 1 - up;
    end
  endtask

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_out = 0; m_mode = 1; m_busy = 0; m_done = 0; m_valid = 1;
      tr_o.delete(); tr_m.delete();
    end else if (m_done != 0) begin
      m_done = 0;
    end else if (bus.abort) begin
      m_busy = 0;
      tr_o.delete(); tr_m.delete();
    end else if (m_busy == 0) begin
      if (bus.start) begin
        build_trace(int'(bus.cfg_limit), int'(bus.cfg_dir), int'(bus.cfg_pingpong), int'(bus.cfg_sweeps));
        m_out = tr_o.pop_front(); m_mode = tr_m.pop_front(); m_busy = 1;
      end
`ifdef COUNTER_SEQ_PAUSE_EN
    end else if (bus.pause) begin
      m_busy = 1;
`endif
    end else if (tr_o.size() == 0) begin
      m_busy = 0; m_done = 1;
    end else begin
      m_out = tr_o.pop_front(); m_mode = tr_m.pop_front();
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_valid != 0) begin
      chk("model_out",  int'(bus.count), m_out);
      chk("model_mode", int'(bus.mode),  m_mode);
      chk("model_busy", int'(bus.busy),  m_busy);
      chk("model_done", int'(bus.done),  m_done);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic run_start(input int lim, input int dir, input int pp, input int n);
    bus.cfg_limit    = WIDTH'(lim);
    bus.cfg_dir      = dir[0];
    bus.cfg_pingpong = pp[0];
    bus.cfg_sweeps   = NSW'(n);
    bus.start        = 1'b1;
    tick();
    bus.start        = 1'b0;
    bus.cfg_limit    = 4'hE;
    bus.cfg_dir      = ~dir[0];
    bus.cfg_pingpong = ~pp[0];
    bus.cfg_sweeps   = 4'h1;
  endtask

  int e34[8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
  int e35o[7] = '{0, 1, 2, 1, 0, 1, 2};
  int e35m[7] = '{1, 1, 1, 0, 0, 1, 1};
  int e36[8]  = '{5, 4, 3, 2, 1, 0, 5, 4};

  initial begin
    bus.start = 1'b1; bus.abort = 1'b0; bus.pause = 1'b0;
    bus.cfg_limit = 4'h9; bus.cfg_dir = 1'b1; bus.cfg_pingpong = 1'b0; bus.cfg_sweeps = '0;
    rst = 1'b1;
    tick();
    chk("rst_out", int'(bus.count), 0);
    chk("rst_mode", int'(bus.mode), 1);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    tick();
    rst = 1'b0; bus.start = 1'b0;
    tick();

    // up, reload, two sweeps; a mid-run start with other config is ignored
    run_start(3, 1, 0, 2);
    for (int i = 0; i < 8; i++) begin
      chk("r34_out", int'(bus.count), e34[i]);
      chk("r34_busy", int'(bus.busy), 1);
      if (i == 2) begin bus.start = 1'b1; bus.cfg_limit = 4'h9; end
      if (i == 3) bus.start = 1'b0;
      tick();
    end
    chk("r34_done", int'(bus.done), 1);
    chk("r34_fin_out", int'(bus.count), 3);
    chk("r34_fin_busy", int'(bus.busy), 0);
    tick();
    chk("r34_idle_done", int'(bus.done), 0);

    // ping-pong, three sweeps
    run_start(2, 1, 1, 3);
    for (int i = 0; i < 7; i++) begin
      chk("r35_out", int'(bus.count), e35o[i]);
      chk("r35_mode", int'(bus.mode), e35m[i]);
      tick();
    end
    chk("r35_done", int'(bus.done), 1);
    tick();

    // down, continuous, aborted on the 8th run cycle
    run_start(5, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      chk("r36_out", int'(bus.count), e36[i]);
      if (i == 7) bus.abort = 1'b1;
      tick();
    end
    bus.abort = 1'b0;
    chk("r36_hold", int'(bus.count), 4);
    chk("r36_busy", int'(bus.busy), 0);
    repeat (3) tick();
    chk("r36_nodone", int'(bus.done), 0);
    chk("r36_hold2", int'(bus.count), 4);

    // abort beats start; reset mid-run, then immediate restart
    bus.start = 1'b1; bus.abort = 1'b1; bus.cfg_limit = 4'h5; bus.cfg_dir = 1'b1;
    tick();
    bus.start = 1'b0; bus.abort = 1'b0;
    chk("r37_idle_busy", int'(bus.busy), 0);
    chk("r37_idle_out", int'(bus.count), 4);
    run_start(7, 1, 0, 0);
    tick();
    tick();
    chk("r37_run3", int'(bus.count), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("r37_rst_out", int'(bus.count), 0);
    chk("r37_rst_mode", int'(bus.mode), 1);
    chk("r37_rst_done", int'(bus.done), 0);
    run_start(4, 0, 0, 1);
    chk("r37_restart_out", int'(bus.count), 4);
    chk("r37_restart_mode", int'(bus.mode), 0);
    repeat (5) tick();
    chk("r37_restart_done", int'(bus.done), 1);
    tick();

    // abort on the completing endpoint suppresses done
    run_start(1, 1, 0, 1);
    tick();
    chk("abend_out", int'(bus.count), 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abend_done", int'(bus.done), 0);
    chk("abend_busy", int'(bus.busy), 0);
    tick();
    chk("abend_done2", int'(bus.done), 0);

    // zero limit: ping-pong toggles mode each cycle, count pinned at 0
    run_start(0, 1, 1, 0);
    for (int i = 0; i < 6; i++) begin
      chk("l0_out", int'(bus.count), 0);
      chk("l0_mode", int'(bus.mode), (i % 2 == 0) ? 1 : 0);
      tick();
    end
    bus.abort = 1'b1; tick(); bus.abort = 1'b0;
    run_start(0, 0, 0, 3);
    repeat (3) tick();
    chk("l0_n3_done", int'(bus.done), 1);
    chk("l0_n3_mode", int'(bus.mode), 0);
    tick();

    // long continuous ping-pong wraps the sweep counter without completing
    run_start(1, 0, 1, 0);
    repeat (40) tick();
    chk("wrap_busy", int'(bus.busy), 1);
    bus.abort = 1'b1; tick(); bus.abort = 1'b0;
    chk("wrap_abort_busy", int'(bus.busy), 0);

    // pause: no effect in idle, freezes a run only when enabled
    bus.pause = 1'b1;
    run_start(7, 1, 0, 1);
    bus.pause = 1'b0;
    chk("pz_start_out", int'(bus.count), 0);
    chk("pz_start_busy", int'(bus.busy), 1);
    tick();
    tick();
    chk("pz_at2", int'(bus.count), 2);
    bus.pause = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
`ifdef COUNTER_SEQ_PAUSE_EN
      chk("pz_hold", int'(bus.count), 2);
`else
      chk("pz_nohold", int'(bus.count), 3 + k);
`endif
      chk("pz_busy", int'(bus.busy), 1);
    end
    bus.pause = 1'b0;
    tick();
`ifdef COUNTER_SEQ_PAUSE_EN
    chk("pz_resume", int'(bus.count), 3);
`else
    chk("pz_resume", int'(bus.count), 7);
`endif
    repeat (8) tick();
    chk("final_idle_busy", int'(bus.busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
